// File: rtl/puf_seq_pkg.sv
// Shared definitions for the PUF scan sequencer.
// Holds the sequencer state encoding and a ceiling-log2 helper.
// The helper sizes the bit index and phase counter from the parameters.
// This file has no ports.
package puf_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        TRIG,
        HOLD,
        RECV
    } state_e;

    // Returns the number of bits needed to hold the values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/puf_phase_gen.sv
// Phase generator for the PUF scan chains.
// A free-running counter splits each frame into four slots of SLOT_CYCLES clocks.
// Ports:
//   clk_i  : system clock
//   rst_ni : synchronous active-low reset
//   ph1_o  : registered phase-1 clock, high during slot 0
//   ph2_o  : registered phase-2 clock, high during slot 2
//   tick_o : high in the last cycle of every frame
module puf_phase_gen
    import puf_seq_pkg::*;
#(
    parameter int SLOT_CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic ph1_o,
    output logic ph2_o,
    output logic tick_o
);

    localparam int FRAME_CYCLES = 4 * SLOT_CYCLES;
    localparam int PC_W         = clog2(FRAME_CYCLES);

    typedef logic [PC_W-1:0] pc_t;

    localparam pc_t PC_LAST   = pc_t'(FRAME_CYCLES - 1);
    localparam pc_t PH1_END   = pc_t'(SLOT_CYCLES);
    localparam pc_t PH2_BEGIN = pc_t'(2 * SLOT_CYCLES);
    localparam pc_t PH2_END   = pc_t'(3 * SLOT_CYCLES);

    pc_t  pc_q, pc_d;
    logic ph1_q, ph1_d;
    logic ph2_q, ph2_d;

    // The phase outputs are decoded from the next counter value.
    // Registering them lines each phase up with its counter value, so the
    // phase clocks leave a flop with no decode glitches.
    always_comb begin
        pc_d  = (pc_q == PC_LAST) ? '0 : pc_q + pc_t'(1);
        ph1_d = (pc_d < PH1_END);
        ph2_d = (pc_d >= PH2_BEGIN) && (pc_d < PH2_END);
    end

    // Counter and phase flops. The counter runs in every state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q  <= '0;
            ph1_q <= 1'b0;
            ph2_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ph1_q <= ph1_d;
            ph2_q <= ph2_d;
        end
    end

    assign ph1_o  = ph1_q;
    assign ph2_o  = ph2_q;
    assign tick_o = (pc_q == PC_LAST);

endmodule

// File: rtl/puf_scan_sequencer.sv
// PUF scan sequencer. It shifts two latched challenges into the PUF one bit per
// frame. It then waits, fires the trigger, and captures NUM_CHAINS serial
// response chains into a parallel register.
// Ports:
//   clk_i, rst_ni          : clock, synchronous active-low reset
//   ex_start_i, ex_abort_i : start request, abort request
//   challenge_a/b_i        : challenges, latched when a start is accepted
//   busy_o, ex_done_o      : operation in progress, one-cycle completion pulse
//   aborted_o              : one-cycle pulse when an abort is taken
//   resp_valid_o           : response register holds a complete result
//   response_o             : chain c occupies bits [c*CH_W +: CH_W]
//   ph1_o, ph2_o           : PUF phase clocks
//   ph_en_o, out_en_o      : PUF input and output shift enables
//   trig_o                 : PUF execute trigger
//   ca_si_o, cb_si_o       : serial challenge bits to the PUF
//   so_i                   : serial response bits from the PUF
module puf_scan_sequencer
    import puf_seq_pkg::*;
#(
    parameter int CH_W        = 128,
    parameter int NUM_CHAINS  = 4,
    parameter int SLOT_CYCLES = 1,
    parameter int TRIG_WAIT   = 6,
    parameter int MSB_FIRST   = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       ex_start_i,
    input  logic                       ex_abort_i,
    input  logic [CH_W-1:0]            challenge_a_i,
    input  logic [CH_W-1:0]            challenge_b_i,
    output logic                       busy_o,
    output logic                       ex_done_o,
    output logic                       aborted_o,
    output logic                       resp_valid_o,
    output logic [NUM_CHAINS*CH_W-1:0] response_o,
    output logic                       ph1_o,
    output logic                       ph2_o,
    output logic                       ph_en_o,
    output logic                       out_en_o,
    output logic                       trig_o,
    output logic                       ca_si_o,
    output logic                       cb_si_o,
    input  logic [NUM_CHAINS-1:0]      so_i
);

    localparam int IDX_W = clog2(CH_W);

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t       IDX_FIRST = (MSB_FIRST != 0) ? idx_t'(CH_W - 1) : '0;
    localparam idx_t       IDX_LAST  = (MSB_FIRST != 0) ? '0 : idx_t'(CH_W - 1);
    localparam logic [7:0] WAIT_LAST = 8'(TRIG_WAIT - 1);

    logic tick;

    state_e                             state_q, state_d;
    logic                               pending_q, pending_d;
    idx_t                               idx_q, idx_d;
    idx_t                               idx_next;
    logic [7:0]                         wait_q, wait_d;
    logic [CH_W-1:0]                    cha_q, cha_d;
    logic [CH_W-1:0]                    chb_q, chb_d;
    logic [NUM_CHAINS-1:0][CH_W-1:0]    resp_q, resp_d;
    logic                               busy_q, busy_d;
    logic                               done_q, done_d;
    logic                               aborted_q, aborted_d;
    logic                               valid_q, valid_d;
    logic                               ph_en_q, ph_en_d;
    logic                               out_en_q, out_en_d;
    logic                               trig_q, trig_d;
    logic                               ca_si_q, ca_si_d;
    logic                               cb_si_q, cb_si_d;

    puf_phase_gen #(
        .SLOT_CYCLES (SLOT_CYCLES)
    ) u_phase (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ph1_o  (ph1_o),
        .ph2_o  (ph2_o),
        .tick_o (tick)
    );

    assign idx_next = (MSB_FIRST != 0) ? idx_q - idx_t'(1) : idx_q + idx_t'(1);

    // Next-state logic. Abort overrides everything else, including a
    // completion on the same edge. A start request only takes effect in IDLE
    // with nothing pending. All other progress waits for the frame tick, so
    // every PUF control holds steady for whole frames.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        wait_d    = wait_q;
        cha_d     = cha_q;
        chb_d     = chb_q;
        resp_d    = resp_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        valid_d   = valid_q;
        ph_en_d   = ph_en_q;
        out_en_d  = out_en_q;
        trig_d    = trig_q;
        ca_si_d   = ca_si_q;
        cb_si_d   = cb_si_q;

        if (ex_abort_i && ((state_q != IDLE) || pending_q)) begin
            state_d   = IDLE;
            pending_d = 1'b0;
            busy_d    = 1'b0;
            aborted_d = 1'b1;
            valid_d   = 1'b0;
            ph_en_d   = 1'b0;
            out_en_d  = 1'b0;
            trig_d    = 1'b0;
            ca_si_d   = 1'b0;
            cb_si_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        if (tick) begin
                            state_d   = SEND;
                            pending_d = 1'b0;
                            idx_d     = IDX_FIRST;
                            ph_en_d   = 1'b1;
                            ca_si_d   = cha_q[IDX_FIRST];
                            cb_si_d   = chb_q[IDX_FIRST];
                        end
                    end else if (ex_start_i && !ex_abort_i) begin
                        cha_d     = challenge_a_i;
                        chb_d     = challenge_b_i;
                        busy_d    = 1'b1;
                        valid_d   = 1'b0;
                        pending_d = 1'b1;
                    end
                end
                SEND: begin
                    if (tick) begin
                        if (idx_q == IDX_LAST) begin
                            ph_en_d = 1'b0;
                            ca_si_d = 1'b0;
                            cb_si_d = 1'b0;
                            wait_d  = '0;
                            if (TRIG_WAIT == 0) begin
                                state_d = TRIG;
                                trig_d  = 1'b1;
                            end else begin
                                state_d = WAIT;
                            end
                        end else begin
                            idx_d   = idx_next;
                            ca_si_d = cha_q[idx_next];
                            cb_si_d = chb_q[idx_next];
                        end
                    end
                end
                WAIT: begin
                    if (tick) begin
                        if (wait_q == WAIT_LAST) begin
                            state_d = TRIG;
                            trig_d  = 1'b1;
                        end else begin
                            wait_d = wait_q + 8'd1;
                        end
                    end
                end
                TRIG: begin
                    if (tick) begin
                        state_d = HOLD;
                        trig_d  = 1'b0;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state_d  = RECV;
                        out_en_d = 1'b1;
                        idx_d    = IDX_FIRST;
                    end
                end
                RECV: begin
                    if (tick) begin
                        for (int c = 0; c < NUM_CHAINS; c++) begin
                            resp_d[c][idx_q] = so_i[c];
                        end
                        if (idx_q == IDX_LAST) begin
                            state_d  = IDLE;
                            out_en_d = 1'b0;
                            done_d   = 1'b1;
                            valid_d  = 1'b1;
                            busy_d   = 1'b0;
                        end else begin
                            idx_d = idx_next;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers. Every output is driven from a flop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            idx_q     <= '0;
            wait_q    <= '0;
            cha_q     <= '0;
            chb_q     <= '0;
            resp_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            valid_q   <= 1'b0;
            ph_en_q   <= 1'b0;
            out_en_q  <= 1'b0;
            trig_q    <= 1'b0;
            ca_si_q   <= 1'b0;
            cb_si_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            wait_q    <= wait_d;
            cha_q     <= cha_d;
            chb_q     <= chb_d;
            resp_q    <= resp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            valid_q   <= valid_d;
            ph_en_q   <= ph_en_d;
            out_en_q  <= out_en_d;
            trig_q    <= trig_d;
            ca_si_q   <= ca_si_d;
            cb_si_q   <= cb_si_d;
        end
    end

    assign busy_o       = busy_q;
    assign ex_done_o    = done_q;
    assign aborted_o    = aborted_q;
    assign resp_valid_o = valid_q;
    assign response_o   = resp_q;
    assign ph_en_o      = ph_en_q;
    assign out_en_o     = out_en_q;
    assign trig_o       = trig_q;
    assign ca_si_o      = ca_si_q;
    assign cb_si_o      = cb_si_q;

endmodule

// File: tb/tb_puf_scan_sequencer.sv
// Testbench for puf_scan_sequencer. Three configurations run side by side:
//   uA: defaults (128-bit, 4 chains, one-cycle slots, six wait frames)
//   uB: 8-bit, 2 chains, MSB first, two wait frames
//   uC: 4-bit, 1 chain, three-cycle slots, no wait frames
// Inputs change on the falling clock edge, and outputs are read there too.
module tb_puf_scan_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Configuration A signals
    logic         aStart, aAbort, aBusy, aDone, aAborted, aValid;
    logic [127:0] aChA, aChB;
    logic [511:0] aResp;
    logic         aPh1, aPh2, aPhEn, aOutEn, aTrig, aCa, aCb;
    logic [3:0]   aSo;

    // Configuration B signals
    logic         bStart, bAbort, bBusy, bDone, bAborted, bValid;
    logic [7:0]   bChA, bChB, bPat;
    logic [15:0]  bResp;
    logic         bPh1, bPh2, bPhEn, bOutEn, bTrig, bCa, bCb;
    logic [1:0]   bSo;

    // Configuration C signals
    logic         cStart, cAbort, cBusy, cDone, cAborted, cValid;
    logic [3:0]   cChA, cChB, cResp;
    logic         cPh1, cPh2, cPhEn, cOutEn, cTrig, cCa, cCb;
    logic [0:0]   cSo;

    puf_scan_sequencer uA (
        .clk_i(clk), .rst_ni(rst_n), .ex_start_i(aStart), .ex_abort_i(aAbort),
        .challenge_a_i(aChA), .challenge_b_i(aChB), .busy_o(aBusy), .ex_done_o(aDone),
        .aborted_o(aAborted), .resp_valid_o(aValid), .response_o(aResp), .ph1_o(aPh1),
        .ph2_o(aPh2), .ph_en_o(aPhEn), .out_en_o(aOutEn), .trig_o(aTrig),
        .ca_si_o(aCa), .cb_si_o(aCb), .so_i(aSo)
    );

    puf_scan_sequencer #(
        .CH_W(8), .NUM_CHAINS(2), .SLOT_CYCLES(1), .TRIG_WAIT(2), .MSB_FIRST(1)
    ) uB (
        .clk_i(clk), .rst_ni(rst_n), .ex_start_i(bStart), .ex_abort_i(bAbort),
        .challenge_a_i(bChA), .challenge_b_i(bChB), .busy_o(bBusy), .ex_done_o(bDone),
        .aborted_o(bAborted), .resp_valid_o(bValid), .response_o(bResp), .ph1_o(bPh1),
        .ph2_o(bPh2), .ph_en_o(bPhEn), .out_en_o(bOutEn), .trig_o(bTrig),
        .ca_si_o(bCa), .cb_si_o(bCb), .so_i(bSo)
    );

    puf_scan_sequencer #(
        .CH_W(4), .NUM_CHAINS(1), .SLOT_CYCLES(3), .TRIG_WAIT(0), .MSB_FIRST(0)
    ) uC (
        .clk_i(clk), .rst_ni(rst_n), .ex_start_i(cStart), .ex_abort_i(cAbort),
        .challenge_a_i(cChA), .challenge_b_i(cChB), .busy_o(cBusy), .ex_done_o(cDone),
        .aborted_o(cAborted), .resp_valid_o(cValid), .response_o(cResp), .ph1_o(cPh1),
        .ph2_o(cPh2), .ph_en_o(cPhEn), .out_en_o(cOutEn), .trig_o(cTrig),
        .ca_si_o(cCa), .cb_si_o(cCb), .so_i(cSo)
    );

    // Runs one operation on configuration B. The PUF model returns bPat on
    // chain 0 and its inverse on chain 1, one bit per RECV frame, first frame =
    // bPat[7]. The serial challenge bits are sampled in the middle of each SEND
    // frame.
    task automatic runB(input bit holdStart, output logic [7:0] caSeq, output logic [7:0] cbSeq,
                        output int doneCount, output int sendEntries, output int doneCycles,
                        output bit busyAtDone, output bit timedOut);
        int         sendStart;
        int         doneAt;
        int         recvCycle;
        logic       prevPhEn;
        logic [2:0] fb;
        caSeq = '0; cbSeq = '0; doneCount = 0; sendEntries = 0; doneCycles = -1;
        busyAtDone = 1'b1; timedOut = 1'b1;
        sendStart = -1; doneAt = -1; recvCycle = 0; prevPhEn = 1'b0;
        if (!holdStart) begin
            @(negedge clk); bStart = 1'b1;
            @(negedge clk); bStart = 1'b0;
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (bPhEn && !prevPhEn) begin
                sendEntries++;
                if (sendStart < 0) sendStart = cyc;
            end
            prevPhEn = bPhEn;
            if (bPhEn && (((cyc - sendStart) % 4) == 2)) begin
                caSeq = {caSeq[6:0], bCa};
                cbSeq = {cbSeq[6:0], bCb};
            end
            if (holdStart && sendStart >= 0 && (cyc - sendStart) == 10) bChA = ~bChA;
            if (bOutEn) begin
                fb = 3'(7 - recvCycle / 4);
                bSo = {~bPat[fb], bPat[fb]};
                recvCycle++;
            end else begin
                bSo = '0;
            end
            if (bDone) begin
                doneCount++;
                if (doneAt < 0) begin
                    doneAt = cyc;
                    busyAtDone = bBusy;
                    doneCycles = cyc - sendStart;
                end
            end
            if (doneAt >= 0 && cyc == doneAt + 3) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({aBusy, aDone, aAborted, aValid, aPh1, aPh2, aPhEn, aOutEn, aTrig, aCa, aCb} !== 11'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl_A got %b want 0",
                     {aBusy, aDone, aAborted, aValid, aPh1, aPh2, aPhEn, aOutEn, aTrig, aCa, aCb});
        end
        checks++;
        if (aResp !== '0) begin
            errors++; $display("[TB] FAIL reset_resp_A got %h want 0", aResp);
        end
        checks++;
        if ({bBusy, bDone, bAborted, bValid, bPh1, bPh2, bPhEn, bOutEn, bTrig, bCa, bCb, bResp} !== 27'b0) begin
            errors++; $display("[TB] FAIL reset_B got %b want 0", {bBusy, bValid, bPh1, bPh2, bPhEn, bResp});
        end
        checks++;
        if ({cBusy, cDone, cAborted, cValid, cPh1, cPh2, cPhEn, cOutEn, cTrig, cCa, cCb, cResp} !== 15'b0) begin
            errors++; $display("[TB] FAIL reset_C got %b want 0", {cBusy, cValid, cPh1, cPh2, cPhEn, cResp});
        end
        rst_n = 1'b1;
    endtask

    // Default configuration. The PUF model echoes both challenges and their
    // inverses on the four chains.
    task automatic test_default_run();
        int         phEnCycles, caCycles, caLate, cbCycles, trigCycles, doneCount;
        int         sendStart, phEnFall, trigRise, doneAt, recvCycle;
        logic [6:0] fa;
        phEnCycles = 0; caCycles = 0; caLate = 0; cbCycles = 0; trigCycles = 0; doneCount = 0;
        sendStart = -1; phEnFall = -1; trigRise = -1; doneAt = -1; recvCycle = 0;
        aChA = 128'h1;
        aChB = '1;
        @(negedge clk); aStart = 1'b1;
        @(negedge clk); aStart = 1'b0;
        checks++;
        if (aBusy !== 1'b1) begin
            errors++; $display("[TB] FAIL A_busy_on_start got %b want 1", aBusy);
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (aPhEn) begin
                if (sendStart < 0) sendStart = cyc;
                phEnCycles++;
            end else if (sendStart >= 0 && phEnFall < 0) begin
                phEnFall = cyc;
            end
            if (aCa) begin
                caCycles++;
                if (sendStart < 0 || (cyc - sendStart) >= 4) caLate++;
            end
            if (aCb) cbCycles++;
            if (aTrig) begin
                trigCycles++;
                if (trigRise < 0) trigRise = cyc;
            end
            if (aOutEn) begin
                fa = 7'(recvCycle / 4);
                aSo = {~aChB[fa], ~aChA[fa], aChB[fa], aChA[fa]};
                recvCycle++;
            end else begin
                aSo = '0;
            end
            if (aDone) begin
                doneCount++;
                if (doneAt < 0) doneAt = cyc;
            end
            if (doneAt >= 0 && cyc == doneAt + 3) break;
        end
        checks++;
        if (doneAt < 0) begin
            errors++; $display("[TB] FAIL A_timeout got no done want done");
        end
        checks++;
        if (phEnCycles != 512) begin
            errors++; $display("[TB] FAIL A_ph_en_cycles got %0d want 512", phEnCycles);
        end
        checks++;
        if (caCycles != 4 || caLate != 0) begin
            errors++; $display("[TB] FAIL A_ca_si_frame0 got %0d high (%0d late) want 4 (0)", caCycles, caLate);
        end
        checks++;
        if (cbCycles != 512) begin
            errors++; $display("[TB] FAIL A_cb_si_cycles got %0d want 512", cbCycles);
        end
        checks++;
        if (trigCycles != 4) begin
            errors++; $display("[TB] FAIL A_trig_cycles got %0d want 4", trigCycles);
        end
        checks++;
        if (trigRise - phEnFall != 24) begin
            errors++; $display("[TB] FAIL A_trig_delay got %0d want 24", trigRise - phEnFall);
        end
        checks++;
        if (doneAt - sendStart != 1056) begin
            errors++; $display("[TB] FAIL A_done_latency got %0d want 1056", doneAt - sendStart);
        end
        checks++;
        if (doneCount != 1) begin
            errors++; $display("[TB] FAIL A_done_pulses got %0d want 1", doneCount);
        end
        checks++;
        if (aResp !== {~aChB, ~aChA, aChB, aChA}) begin
            errors++; $display("[TB] FAIL A_response got %h want %h", aResp, {~aChB, ~aChA, aChB, aChA});
        end
        checks++;
        if (aValid !== 1'b1 || aBusy !== 1'b0) begin
            errors++; $display("[TB] FAIL A_valid_busy got %b%b want 10", aValid, aBusy);
        end
    endtask

    // MSB-first capture and shift order.
    task automatic test_msb_first();
        logic [7:0] caSeq, cbSeq;
        int         doneCount, sendEntries, doneCycles;
        bit         busyAtDone, timedOut;
        bChA = 8'hA5; bChB = 8'h3C; bPat = 8'b10110010;
        runB(1'b0, caSeq, cbSeq, doneCount, sendEntries, doneCycles, busyAtDone, timedOut);
        checks++;
        if (timedOut) begin
            errors++; $display("[TB] FAIL B_timeout got no done want done");
        end
        checks++;
        if (caSeq !== 8'hA5 || cbSeq !== 8'h3C) begin
            errors++; $display("[TB] FAIL B_serial_order got %h/%h want a5/3c", caSeq, cbSeq);
        end
        checks++;
        if (bResp !== 16'b01001101_10110010) begin
            errors++; $display("[TB] FAIL B_response got %b want 0100110110110010", bResp);
        end
        checks++;
        if (doneCycles != 80 || doneCount != 1) begin
            errors++; $display("[TB] FAIL B_done got %0d cycles %0d pulses want 80 1", doneCycles, doneCount);
        end
        checks++;
        if (bValid !== 1'b1 || bBusy !== 1'b0) begin
            errors++; $display("[TB] FAIL B_valid_busy got %b%b want 10", bValid, bBusy);
        end
    endtask

    // Start held high through a whole run, with challenge A flipped mid-SEND.
    task automatic test_start_held();
        logic [7:0] caSeq, cbSeq;
        int         doneCount, sendEntries, doneCycles;
        bit         busyAtDone, timedOut;
        bChA = 8'h96; bChB = 8'h0F; bPat = 8'hC3;
        @(negedge clk); bStart = 1'b1;
        runB(1'b1, caSeq, cbSeq, doneCount, sendEntries, doneCycles, busyAtDone, timedOut);
        checks++;
        if (timedOut || sendEntries != 1 || doneCount != 1) begin
            errors++; $display("[TB] FAIL held_single_run got %0d sends %0d dones to=%0b want 1 1 0",
                               sendEntries, doneCount, timedOut);
        end
        checks++;
        if (caSeq !== 8'h96) begin
            errors++; $display("[TB] FAIL held_latched_ca got %h want 96", caSeq);
        end
        checks++;
        if (busyAtDone !== 1'b0 || bBusy !== 1'b1) begin
            errors++; $display("[TB] FAIL held_restart got busy %b at done %b after want 0 1", busyAtDone, bBusy);
        end
        bStart = 1'b0;
        bAbort = 1'b1;
        @(negedge clk); bAbort = 1'b0;
        @(negedge clk);
    endtask

    // Aborts in RECV frame 5 and while a start is pending, then runs a normal operation.
    task automatic test_abort();
        logic [7:0] caSeq, cbSeq;
        int         doneCount, sendEntries, doneCycles, abortCount, found;
        bit         busyAtDone, timedOut;
        bChA = 8'h11; bChB = 8'h22; bPat = 8'hFF;
        @(negedge clk); bStart = 1'b1;
        @(negedge clk); bStart = 1'b0;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bOutEn) begin found = 1; break; end
        end
        repeat (21) @(negedge clk);
        checks++;
        if (found == 0 || bOutEn !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_reach_recv got out_en %b want 1", bOutEn);
        end
        bAbort = 1'b1;
        @(negedge clk); bAbort = 1'b0;
        checks++;
        if ({bAborted, bOutEn, bBusy, bValid} !== 4'b1000) begin
            errors++; $display("[TB] FAIL abort_recv got %b want 1000", {bAborted, bOutEn, bBusy, bValid});
        end
        abortCount = 1; doneCount = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bAborted) abortCount++;
            if (bDone) doneCount++;
        end
        checks++;
        if (abortCount != 1 || doneCount != 0) begin
            errors++; $display("[TB] FAIL abort_pulses got %0d aborts %0d dones want 1 0", abortCount, doneCount);
        end
        @(negedge clk); bStart = 1'b1;
        @(negedge clk); bStart = 1'b0; bAbort = 1'b1;
        @(negedge clk); bAbort = 1'b0;
        checks++;
        if ({bAborted, bBusy, bPhEn} !== 3'b100) begin
            errors++; $display("[TB] FAIL abort_pending got %b want 100", {bAborted, bBusy, bPhEn});
        end
        bPat = 8'h5C;
        runB(1'b0, caSeq, cbSeq, doneCount, sendEntries, doneCycles, busyAtDone, timedOut);
        checks++;
        if (timedOut || bResp !== {~8'h5C, 8'h5C} || bValid !== 1'b1 || doneCount != 1) begin
            errors++; $display("[TB] FAIL abort_rerun got %h valid %b want a35c valid 1", bResp, bValid);
        end
    endtask

    // Three-cycle slots and zero wait frames.
    task automatic test_slot3();
        int         ph1High, ph2High, overlap, ph1Rise, ph2Rise, trigCycles, doneCount;
        int         sendStart, phEnFall, trigRise, doneAt, recvCycle;
        logic       prev1, prev2;
        logic [1:0] fc;
        ph1High = 0; ph2High = 0; overlap = 0; ph1Rise = -1; ph2Rise = -1;
        prev1 = cPh1; prev2 = cPh2;
        for (int cyc = 0; cyc < 36; cyc++) begin
            @(negedge clk);
            if (cyc < 24) begin
                if (cPh1) ph1High++;
                if (cPh2) ph2High++;
                if (cPh1 && cPh2) overlap++;
            end
            if (cPh1 && !prev1 && ph1Rise < 0) ph1Rise = cyc;
            if (cPh2 && !prev2 && ph1Rise >= 0 && ph2Rise < 0) ph2Rise = cyc;
            prev1 = cPh1; prev2 = cPh2;
        end
        checks++;
        if (ph1High != 6 || ph2High != 6 || overlap != 0) begin
            errors++; $display("[TB] FAIL C_duty got %0d %0d %0d want 6 6 0", ph1High, ph2High, overlap);
        end
        checks++;
        if (ph2Rise - ph1Rise != 6) begin
            errors++; $display("[TB] FAIL C_ph2_offset got %0d want 6", ph2Rise - ph1Rise);
        end
        trigCycles = 0; doneCount = 0; sendStart = -1; phEnFall = -1; trigRise = -1; doneAt = -1; recvCycle = 0;
        cChA = 4'b1010; cChB = 4'b0110;
        @(negedge clk); cStart = 1'b1;
        @(negedge clk); cStart = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (cPhEn && sendStart < 0) sendStart = cyc;
            if (!cPhEn && sendStart >= 0 && phEnFall < 0) phEnFall = cyc;
            if (cTrig) begin
                trigCycles++;
                if (trigRise < 0) trigRise = cyc;
            end
            if (cOutEn) begin
                fc = 2'(recvCycle / 12);
                cSo[0] = cChA[fc];
                recvCycle++;
            end else begin
                cSo = '0;
            end
            if (cDone) begin
                doneCount++;
                if (doneAt < 0) doneAt = cyc;
            end
            if (doneAt >= 0 && cyc == doneAt + 3) break;
        end
        checks++;
        if (trigCycles != 12 || trigRise - phEnFall != 0) begin
            errors++; $display("[TB] FAIL C_trig got %0d cycles delay %0d want 12 0", trigCycles, trigRise - phEnFall);
        end
        checks++;
        if (doneAt < 0 || doneAt - sendStart != 120 || doneCount != 1) begin
            errors++; $display("[TB] FAIL C_done got latency %0d pulses %0d want 120 1", doneAt - sendStart, doneCount);
        end
        checks++;
        if (cResp !== 4'b1010 || cValid !== 1'b1) begin
            errors++; $display("[TB] FAIL C_response got %b valid %b want 1010 1", cResp, cValid);
        end
    endtask

    // One-cycle reset in the middle of SEND on configuration B.
    task automatic test_reset_mid_send();
        int found, ph1Delay;
        bChA = 8'hF0; bChB = 8'h0F;
        @(negedge clk); bStart = 1'b1;
        @(negedge clk); bStart = 1'b0;
        found = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bPhEn) begin found = 1; break; end
        end
        repeat (8) @(negedge clk);
        checks++;
        if (found == 0 || bPhEn !== 1'b1) begin
            errors++; $display("[TB] FAIL rst_reach_send got ph_en %b want 1", bPhEn);
        end
        rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        checks++;
        if ({bBusy, bDone, bAborted, bValid, bPh1, bPh2, bPhEn, bOutEn, bTrig, bCa, bCb, bResp} !== 27'b0) begin
            errors++; $display("[TB] FAIL rst_mid_send got %b want 0", {bBusy, bAborted, bValid, bPh1, bPhEn, bResp});
        end
        checks++;
        if (uB.u_phase.pc_q !== '0) begin
            errors++; $display("[TB] FAIL rst_pc got %0d want 0", uB.u_phase.pc_q);
        end
        ph1Delay = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bPh1) begin ph1Delay = i; break; end
        end
        checks++;
        if (ph1Delay != 4) begin
            errors++; $display("[TB] FAIL rst_ph1_restart got %0d want 4", ph1Delay);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        aStart = 1'b0; aAbort = 1'b0; aChA = '0; aChB = '0; aSo = '0;
        bStart = 1'b0; bAbort = 1'b0; bChA = '0; bChB = '0; bSo = '0; bPat = '0;
        cStart = 1'b0; cAbort = 1'b0; cChA = '0; cChB = '0; cSo = '0;
        test_reset();
        test_default_run();
        test_msb_first();
        test_start_held();
        test_abort();
        test_slot3();
        test_reset_mid_send();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
